// File: rtl/apb_completer.sv
// APB completer: word-addressed register bank with byte-strobe writes, programmable wait states and error response.
// Optional read-only ID register at index 0 when APB_COMPLETER_ID_REG_EN is defined.
module apb_completer #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [3:0]            pstrb,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 2;
  localparam int unsigned SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned CNT_W = 4;

`ifdef APB_COMPLETER_ID_REG_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]            state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic                  cap_write;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [3:0]            cap_strb;
  logic                  load_c;
  logic                  wr_en_c;
  logic                  err_c;
  logic                  id_hit_c;
  logic [SEL_W-1:0]      sel_c;
  logic [DATA_WIDTH-1:0] rd_data_c;
  logic                  pready_nxt, pslverr_nxt;
  logic [DATA_WIDTH-1:0] prdata_nxt;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Decode of the captured transfer
  always_comb begin
    sel_c     = cap_addr[SEL_W+1:2];
    id_hit_c  = ID_EN && (cap_addr[ADDR_WIDTH-1:2] == '0);
    err_c     = (cap_addr[1:0] != 2'b00)
             || (cap_addr[ADDR_WIDTH-1:2] >= IDX_W'(NUM_REGS))
             || (id_hit_c && cap_write);
    rd_data_c = id_hit_c ? DATA_WIDTH'(ID_VALUE) : regs[sel_c];
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    load_c      = 1'b0;
    wr_en_c     = 1'b0;
    pready_nxt  = 1'b0;
    pslverr_nxt = 1'b0;
    prdata_nxt  = '0;
    case (state)
      IDLE: begin
        if (psel && !penable) begin
          load_c    = 1'b1;
          cnt_nxt   = CNT_W'(WAIT_CYCLES);
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_nxt   = RESP;
          pready_nxt  = 1'b1;
          pslverr_nxt = 1'b1;
        end else if (penable && (cnt == '0)) begin
          state_nxt  = RESP;
          pready_nxt = 1'b1;
          if (err_c) begin
            pslverr_nxt = 1'b1;
          end else if (cap_write) begin
            wr_en_c = 1'b1;
          end else begin
            prdata_nxt = rd_data_c;
          end
        end else if (penable) begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        // A setup seen during the response starts the next transfer directly
        if (psel && !penable) begin
          load_c    = 1'b1;
          cnt_nxt   = CNT_W'(WAIT_CYCLES);
          state_nxt = ACCESS;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_addr  <= '0;
      cap_write <= 1'b0;
      cap_wdata <= '0;
      cap_strb  <= '0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      prdata    <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pready  <= pready_nxt;
      pslverr <= pslverr_nxt;
      prdata  <= prdata_nxt;
      if (load_c) begin
        cap_addr  <= paddr;
        cap_write <= pwrite;
        cap_wdata <= pwdata;
        cap_strb  <= pstrb;
      end
    end
  end

  // Register bank with per-lane write strobes
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en_c) begin
      for (int l = 0; l < 4; l++) begin
        if (cap_strb[l]) regs[sel_c][8*l +: 8] <= cap_wdata[8*l +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb_completer.sv
// Randomized self-checking bench for apb_completer against a register-array reference model.
module tb_apb_completer;

  localparam int unsigned WAITS = 2;
  localparam logic [31:0] ID    = 32'hA9B0_0001;
`ifdef APB_COMPLETER_ID_REG_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0]  pstrb;
  logic        pready, pslverr;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [16];

  always #5 pclk = ~pclk;

  apb_completer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_CYCLES(WAITS), .ID_VALUE(ID)
  ) dut (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One complete APB transfer; scrambles paddr during wait states
  task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [31:0] rdata,
                          output logic err, output int lows);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    @(negedge pclk);
    penable = 1'b1;
    lows = 0;
    while (pready !== 1'b1 && lows < 40) begin
      lows++;
      paddr = $urandom;
      @(negedge pclk);
    end
    if (lows >= 40) check("pready_timeout", 32'(pready), 32'd1);
    rdata = prdata;
    err   = pslverr;
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    check("pready_one_cycle", 32'(pready), 32'd0);
  endtask

  // Transfer checked against the reference model
  task automatic do_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb);
    logic [31:0] rd, exp_rd;
    logic        err;
    bit          exp_err;
    int          lows;
    int unsigned idx;
    idx     = addr >> 2;
    exp_err = (addr % 4 != 0) || (idx >= 16) || (ID_EN && wr && idx == 0);
    if (exp_err || wr) exp_rd = 32'h0;
    else if (ID_EN && idx == 0) exp_rd = ID;
    else exp_rd = model[idx];
    apb_xfer(wr, addr, data, strb, rd, err, lows);
    check(wr ? "wr_err" : "rd_err", 32'(err), 32'(exp_err));
    check("access_lows", 32'(lows), 32'(WAITS + 1));
    if (!wr) check("rd_data", rd, exp_rd);
    if (wr && !exp_err) begin
      for (int l = 0; l < 4; l++)
        if (strb[l]) model[idx][8*l +: 8] = data[8*l +: 8];
    end
  endtask

  initial begin
    logic [31:0] a;
    int k;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    repeat (3) @(negedge pclk);
    check("rst_pready", 32'(pready), 32'd0);
    check("rst_pslverr", 32'(pslverr), 32'd0);
    check("rst_prdata", prdata, 32'd0);
    preset = 1'b0;

    do_xfer(1'b0, 32'h4, 32'h0, 4'h0);
    do_xfer(1'b1, 32'h4, 32'hDEAD_BEEF, 4'hF);
    do_xfer(1'b1, 32'h4, 32'h1122_3344, 4'b0101);
    do_xfer(1'b0, 32'h4, 32'h0, 4'h0);
    check("lane_merge", model[1], 32'hDE22_BE44);
    do_xfer(1'b1, 32'h4, 32'hFFFF_FFFF, 4'h0);
    do_xfer(1'b0, 32'h4, 32'h0, 4'hF);

    do_xfer(1'b1, 32'h3C, 32'hCAFE_F00D, 4'hF);
    do_xfer(1'b0, 32'h3, 32'h0, 4'h0);
    do_xfer(1'b1, 32'h40, 32'h1234_5678, 4'hF);
    do_xfer(1'b0, 32'h3C, 32'h0, 4'h0);

    // penable without setup must be ignored
    @(negedge pclk);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'h0; pstrb = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      check("no_setup_pready", 32'(pready), 32'd0);
    end
    psel = 1'b0; penable = 1'b0;
    do_xfer(1'b0, 32'h4, 32'h0, 4'h0);

    // psel dropped mid-access
    do_xfer(1'b1, 32'h10, 32'h1234_5678, 4'hF);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel = 1'b0;
    @(negedge pclk);
    check("abort_pready", 32'(pready), 32'd1);
    check("abort_pslverr", 32'(pslverr), 32'd1);
    check("abort_prdata", prdata, 32'd0);
    penable = 1'b0;
    @(negedge pclk);
    check("abort_pready_drop", 32'(pready), 32'd0);
    do_xfer(1'b0, 32'h10, 32'h0, 4'h0);

    // Reset during a write access
    do_xfer(1'b1, 32'h8, 32'h5A5A_5A5A, 4'hF);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    preset = 1'b1;
    #1;
    check("rst_mid_pready", 32'(pready), 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    preset = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    do_xfer(1'b0, 32'h8, 32'h0, 4'h0);
    do_xfer(1'b0, 32'h4, 32'h0, 4'h0);

    // Register 0 / ID behaviour
    do_xfer(1'b0, 32'h0, 32'h0, 4'h0);
    do_xfer(1'b1, 32'h0, 32'h0000_0001, 4'hF);
    do_xfer(1'b0, 32'h0, 32'h0, 4'h0);

    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 9);
      if (k <= 6)      a = 32'($urandom_range(0, 15)) << 2;
      else if (k == 7) a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      else if (k == 8) a = 32'h40 + (32'($urandom_range(0, 63)) << 2);
      else             a = $urandom;
      do_xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 16; i++) do_xfer(1'b0, 32'(i) << 2, 32'h0, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
